// File: rtl/link_arbiter_mc.sv
// Multi-channel link arbiter: grants one shared 8-bit user bus to one of
// NUM_CH link channels at a time, with round-robin fairness, a per-grant
// burst limit, a timed per-channel flush after RX sessions, and a
// one-cycle release gap between grants.
module link_arbiter_mc #(
  parameter  int NUM_CH       = 4,
  parameter  int BURST_MAX    = 8,
  parameter  int FLUSH_CYCLES = 4,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] rx_req,
  input  logic [NUM_CH-1:0] tx_req,
  input  logic [NUM_CH-1:0] tx_fifo_full,
  input  logic [NUM_CH-1:0] rx_fifo_empty,
  output logic [NUM_CH-1:0] rx_ack,
  output logic              occupied,
  output logic [CH_W-1:0]   grant_ch,
  output logic              tx_en,
  output logic              rx_rd_en,
  output logic              bus_dir,
  output logic [NUM_CH-1:0] flush
);

  // Shared beat / flush counter sized for the larger of the two limits.
  localparam int CNT_MAX = (BURST_MAX > FLUSH_CYCLES) ? BURST_MAX : FLUSH_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam bit BURST_ON = (BURST_MAX > 0);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'((BURST_MAX > 0) ? BURST_MAX - 1 : 0);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);

  // One extra bit so rr_ptr + k never overflows before the modulo fold.
  localparam int PW = CH_W + 1;
  localparam logic [PW-1:0]   NUM_CH_P = PW'(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    IDLE,
    TX,
    RX,
    FLUSH,
    RELEASE
  } state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     grant_q, grant_d;
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic                occupied_q, occupied_d;
  logic                bus_dir_q, bus_dir_d;
  logic [NUM_CH-1:0]   rx_ack_q, rx_ack_d;
  logic [NUM_CH-1:0]   flush_q, flush_d;
  logic [NUM_CH-1:0]   grant_oh_d;

  logic [NUM_CH-1:0]   req;
  logic                win_found;
  logic [CH_W-1:0]     win_ch;
  logic [PW-1:0]       cand;

  logic                g_tx_req, g_rx_req, g_full, g_empty;

  assign req      = rx_req | tx_req;
  assign g_tx_req = tx_req[grant_q];
  assign g_rx_req = rx_req[grant_q];
  assign g_full   = tx_fifo_full[grant_q];
  assign g_empty  = rx_fifo_empty[grant_q];

  // Round-robin search: first requester after rr_ptr, folded back below NUM_CH.
  always_comb begin
    win_found = 1'b0;
    win_ch    = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = {1'b0, rr_ptr_q} + PW'(k);
      if (cand >= NUM_CH_P) begin
        cand = cand - NUM_CH_P;
      end
      if (!win_found && req[cand[CH_W-1:0]]) begin
        win_found = 1'b1;
        win_ch    = cand[CH_W-1:0];
      end
    end
  end

  // Next-state, counters, strobes and the registered Moore outputs' next values.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    tx_en      = 1'b0;
    rx_rd_en   = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d    = win_ch;
          rr_ptr_d   = win_ch;
          beat_cnt_d = '0;
          state_d    = rx_req[win_ch] ? RX : TX;
        end
      end
      TX: begin
        tx_en = g_tx_req & ~g_full;
        if (!g_tx_req) begin
          state_d = RELEASE;
        end else if (tx_en) begin
          if (BURST_ON && beat_cnt_q == BURST_LAST) begin
            state_d = RELEASE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      RX: begin
        rx_rd_en = g_rx_req & ~g_empty;
        // Dropping the request ends the session with a flush, even on the
        // same cycle the burst limit would have released it.
        if (!g_rx_req) begin
          state_d    = FLUSH;
          beat_cnt_d = '0;
        end else if (rx_rd_en) begin
          if (BURST_ON && beat_cnt_q == BURST_LAST) begin
            state_d = RELEASE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (beat_cnt_q == FLUSH_LAST) begin
          state_d    = RELEASE;
          beat_cnt_d = '0;
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    occupied_d = (state_d == TX) || (state_d == RX) || (state_d == FLUSH);
    // grant_ch reads 0 whenever the bus is not granted.
    if (!occupied_d) begin
      grant_d = '0;
    end
    grant_oh_d          = '0;
    grant_oh_d[grant_d] = 1'b1;
    bus_dir_d = (state_d == RX);
    rx_ack_d  = (state_d == RX)    ? grant_oh_d : '0;
    flush_d   = (state_d == FLUSH) ? grant_oh_d : '0;
  end

  // State and output registers; reset aborts any session with no flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= LAST_CH;
      beat_cnt_q <= '0;
      occupied_q <= 1'b0;
      bus_dir_q  <= 1'b0;
      rx_ack_q   <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      occupied_q <= occupied_d;
      bus_dir_q  <= bus_dir_d;
      rx_ack_q   <= rx_ack_d;
      flush_q    <= flush_d;
    end
  end

  assign occupied = occupied_q;
  assign grant_ch = grant_q;
  assign bus_dir  = bus_dir_q;
  assign rx_ack   = rx_ack_q;
  assign flush    = flush_q;

endmodule

// File: tb/tb_link_arbiter_mc.sv
// Directed, table-driven bench for link_arbiter_mc (NUM_CH=4, BURST_MAX=8,
// FLUSH_CYCLES=4). Each row is one clock cycle: inputs applied after the
// rising edge, all outputs compared on the falling edge.
module tb_link_arbiter_mc;

  logic       clk;
  logic       rst;
  logic [3:0] rx_req, tx_req, tx_fifo_full, rx_fifo_empty;
  logic [3:0] rx_ack, flush;
  logic       occupied, tx_en, rx_rd_en, bus_dir;
  logic [1:0] grant_ch;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      name;
    logic [3:0] rx, tx, full, empty;
    logic       occ;
    logic [1:0] g;
    logic       te, rd, dir;
    logic [3:0] ack, fl;
  } vec_t;

  vec_t tbl[$];

  link_arbiter_mc #(
    .NUM_CH(4), .BURST_MAX(8), .FLUSH_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_req(rx_req), .tx_req(tx_req),
    .tx_fifo_full(tx_fifo_full), .rx_fifo_empty(rx_fifo_empty),
    .rx_ack(rx_ack), .occupied(occupied), .grant_ch(grant_ch),
    .tx_en(tx_en), .rx_rd_en(rx_rd_en), .bus_dir(bus_dir), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(string n, logic [3:0] rx, logic [3:0] tx, logic [3:0] full,
                              logic [3:0] empty, logic occ, logic [1:0] g, logic te,
                              logic rd, logic dir, logic [3:0] ack, logic [3:0] fl);
    vec_t v;
    v.name = n; v.rx = rx; v.tx = tx; v.full = full; v.empty = empty;
    v.occ = occ; v.g = g; v.te = te; v.rd = rd; v.dir = dir; v.ack = ack; v.fl = fl;
    tbl.push_back(v);
  endfunction

  // Bus not granted (IDLE or RELEASE): every output is 0.
  function automatic void add_idle(string n, logic [3:0] rx, logic [3:0] tx);
    add(n, rx, tx, 4'b0000, 4'b1111, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
  endfunction

  function automatic void add_tx(string n, logic [3:0] tx, logic [3:0] full, logic [1:0] g, logic te);
    add(n, 4'b0000, tx, full, 4'b1111, 1'b1, g, te, 1'b0, 1'b0, 4'b0000, 4'b0000);
  endfunction

  function automatic void add_rx(string n, logic [3:0] rx, logic [3:0] tx, logic [3:0] empty,
                                logic [1:0] g, logic rd);
    add(n, rx, tx, 4'b0000, empty, 1'b1, g, 1'b0, rd, 1'b1, 4'b0001 << g, 4'b0000);
  endfunction

  function automatic void add_fl(string n, logic [1:0] g);
    add(n, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 1'b1, g, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001 << g);
  endfunction

  task automatic check(input string n, input logic [13:0] exp);
    logic [13:0] got;
    got = {occupied, grant_ch, tx_en, rx_rd_en, bus_dir, rx_ack, flush};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got occ=%b g=%0d te=%b rd=%b dir=%b ack=%b fl=%b, want occ=%b g=%0d te=%b rd=%b dir=%b ack=%b fl=%b",
               n, $time, got[13], got[12:11], got[10], got[9], got[8], got[7:4], got[3:0],
               exp[13], exp[12:11], exp[10], exp[9], exp[8], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic step(input vec_t v);
    rx_req = v.rx; tx_req = v.tx; tx_fifo_full = v.full; rx_fifo_empty = v.empty;
    @(negedge clk);
    check(v.name, {v.occ, v.g, v.te, v.rd, v.dir, v.ack, v.fl});
    @(posedge clk);
    #1;
  endtask

  task automatic run_table();
    foreach (tbl[i]) step(tbl[i]);
    tbl.delete();
  endtask

  initial begin
    logic [1:0] rr_order [5];
    rr_order[0] = 2'd0; rr_order[1] = 2'd1; rr_order[2] = 2'd2;
    rr_order[3] = 2'd3; rr_order[4] = 2'd0;

    rst = 1'b1;
    rx_req = '0; tx_req = '0; tx_fifo_full = '0; rx_fifo_empty = '1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset", 14'd0);
    rst = 1'b0;

    // TX on ch2: 8 beats, release, regrant, then drop request.
    add_idle("t1 idle", 4'b0000, 4'b0100);
    for (int i = 0; i < 8; i++) add_tx("t1 beat", 4'b0100, 4'b0000, 2'd2, 1'b1);
    add_idle("t1 release", 4'b0000, 4'b0100);
    add_idle("t1 idle2", 4'b0000, 4'b0100);
    add_tx("t1 regrant", 4'b0100, 4'b0000, 2'd2, 1'b1);
    add_tx("t1 drop", 4'b0000, 4'b0000, 2'd2, 1'b0);
    add_idle("t1 release2", 4'b0000, 4'b0000);
    add_idle("t1 idle3", 4'b0000, 4'b0000);

    // TX on ch1 with a 5-cycle full stall mid-burst; still 8 beats total.
    add_idle("t3 idle", 4'b0000, 4'b0010);
    for (int i = 0; i < 3; i++) add_tx("t3 beat", 4'b0010, 4'b0000, 2'd1, 1'b1);
    for (int i = 0; i < 5; i++) add_tx("t3 stall", 4'b0010, 4'b0010, 2'd1, 1'b0);
    for (int i = 0; i < 5; i++) add_tx("t3 beat", 4'b0010, 4'b0000, 2'd1, 1'b1);
    add_idle("t3 release", 4'b0000, 4'b0000);
    add_idle("t3 idle2", 4'b0000, 4'b0000);

    // RX on ch3, empty toggling, 3 reads, drop -> 4 flush cycles.
    add_idle("t4 idle", 4'b1000, 4'b0000);
    add_rx("t4 empty", 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0);
    add_rx("t4 read", 4'b1000, 4'b0000, 4'b0000, 2'd3, 1'b1);
    add_rx("t4 empty", 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0);
    add_rx("t4 read", 4'b1000, 4'b0000, 4'b0000, 2'd3, 1'b1);
    add_rx("t4 read", 4'b1000, 4'b0000, 4'b0000, 2'd3, 1'b1);
    add_rx("t4 drop", 4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0);
    for (int i = 0; i < 4; i++) add_fl("t4 flush", 2'd3);
    add_idle("t4 release", 4'b0000, 4'b0000);
    add_idle("t4 idle2", 4'b0000, 4'b0000);

    // RX and TX on ch0 together: RX wins, burst limit releases with no flush.
    add_idle("t5 idle", 4'b0001, 4'b0001);
    for (int i = 0; i < 8; i++) add_rx("t5 read", 4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b1);
    add_idle("t5 release", 4'b0000, 4'b0000);
    add_idle("t5 idle2", 4'b0000, 4'b0000);

    run_table();

    // Reach FLUSH on ch2, then assert reset asynchronously mid-flush.
    add_idle("r idle", 4'b0100, 4'b0000);
    add_rx("r rx", 4'b0100, 4'b0000, 4'b1111, 2'd2, 1'b0);
    add_rx("r drop", 4'b0000, 4'b0000, 4'b1111, 2'd2, 1'b0);
    add_fl("r flush", 2'd2);
    run_table();
    #3;
    rst = 1'b1;
    #1;
    check("async reset in flush", 14'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // After reset the round-robin pointer restarts: order 0,1,2,3,0.
    add_idle("rr idle", 4'b0000, 4'b1111);
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < 8; i++) add_tx("rr beat", 4'b1111, 4'b0000, rr_order[c], 1'b1);
      add_idle("rr release", 4'b0000, 4'b1111);
      add_idle("rr idle", 4'b0000, 4'b1111);
    end
    run_table();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
